// File: rtl/convolution_coprocessor_pkg.sv
// convolution_coprocessor_pkg: shared state type and length helper for the index sequencer.
// Rev 1.0
`default_nettype none

package convolution_coprocessor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   function automatic int unsigned conv_out_len(input int unsigned nx, input int unsigned nh);
      return nx + nh - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/convolution_coprocessor_nested_counter.sv
// convolution_coprocessor_nested_counter: (outer,inner) = (n,k) pair, inner wraps at inner_limit.
// Rev 1.0
`default_nettype none

module convolution_coprocessor_nested_counter #(
   parameter int INNER_W = 5,
   parameter int OUTER_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               advance,
   input  logic [INNER_W:0]   inner_limit,
   input  logic [OUTER_W-1:0] outer_limit,
   output logic [INNER_W-1:0] inner_d,
   output logic [OUTER_W-1:0] outer_d,
   output logic               inner_last,
   output logic               outer_last
);

   logic [INNER_W-1:0] inner_q;
   logic [OUTER_W-1:0] outer_q;

   assign inner_last = ({1'b0, inner_q} == (inner_limit - 1'b1));
   assign outer_last = (outer_q == (outer_limit - 1'b1));

   // Next values are exported so the owner can register outputs decoded from them.
   always_comb begin
      inner_d = inner_q;
      outer_d = outer_q;
      if (clear) begin
         inner_d = '0;
         outer_d = '0;
      end else if (advance) begin
         if (inner_last) begin
            inner_d = '0;
            outer_d = outer_q + 1'b1;
         end else begin
            inner_d = inner_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inner_q <= '0;
         outer_q <= '0;
      end else begin
         inner_q <= inner_d;
         outer_q <= outer_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/convolution_coprocessor_index_sequencer.sv
// convolution_coprocessor_index_sequencer: walks (n,k) for y[n] = sum x[k]*h[n-k] and emits addresses/flags.
// Rev 1.0
`default_nettype none

module convolution_coprocessor_index_sequencer
   import convolution_coprocessor_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   size_x_i,
   input  logic [ADDR_WIDTH:0]   size_h_i,
   input  logic                  ready_i,
   output logic                  step_valid_o,
   output logic [ADDR_WIDTH-1:0] addr_x_o,
   output logic [ADDR_WIDTH-1:0] addr_h_o,
   output logic [ADDR_WIDTH:0]   addr_y_o,
   output logic [ADDR_WIDTH+1:0] index_h_o,
   output logic                  index_h_less_than_zero_o,
   output logic                  index_h_out_of_range_o,
   output logic                  acc_clear_o,
   output logic                  y_write_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int SW = ADDR_WIDTH + 1;
   localparam int IW = ADDR_WIDTH + 2;
   localparam logic [SW-1:0] MAX_LEN = SW'(1) << ADDR_WIDTH;

   function automatic logic [SW-1:0] sat_len(input logic [SW-1:0] v);
      return (v > MAX_LEN) ? MAX_LEN : v;
   endfunction

   seq_state_t state_q, state_d;
   logic [SW-1:0] nx_q, nx_d, nh_q, nh_d;
   logic [SW-1:0] ny;
   logic          cnt_clear, cnt_advance, inner_last, outer_last;
   logic [ADDR_WIDTH-1:0] k_d;
   logic [SW-1:0]         n_d;

   logic                  step_valid_q, step_valid_d;
   logic [ADDR_WIDTH-1:0] addr_x_q, addr_x_d, addr_h_q, addr_h_d;
   logic [SW-1:0]         addr_y_q, addr_y_d;
   logic [IW-1:0]         index_h_q, index_h_d;
   logic                  lt0_q, lt0_d, oor_q, oor_d;
   logic                  acc_clear_q, acc_clear_d, y_write_q, y_write_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  run_d;

   assign ny = SW'(conv_out_len(32'(nx_q), 32'(nh_q)));

   convolution_coprocessor_nested_counter #(
      .INNER_W (ADDR_WIDTH),
      .OUTER_W (SW)
   ) u_counter (
      .clk         (clk),
      .rst         (rst),
      .clear       (cnt_clear),
      .advance     (cnt_advance),
      .inner_limit (nx_q),
      .outer_limit (ny),
      .inner_d     (k_d),
      .outer_d     (n_d),
      .inner_last  (inner_last),
      .outer_last  (outer_last)
   );

   always_comb begin
      state_d     = state_q;
      nx_d        = nx_q;
      nh_d        = nh_q;
      cnt_clear   = 1'b0;
      cnt_advance = (state_q == RUN) && ready_i;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               nx_d      = sat_len(size_x_i);
               nh_d      = sat_len(size_h_i);
               cnt_clear = 1'b1;
               state_d   = ((nx_d == '0) || (nh_d == '0)) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_advance && inner_last && outer_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next (n,k) and state so every port comes straight from a flop;
   // a stall leaves (n,k) unchanged and therefore re-registers identical values.
   always_comb begin
      run_d        = (state_d == RUN);
      index_h_d    = {1'b0, n_d} - {2'b00, k_d};
      lt0_d        = index_h_d[IW-1];
      oor_d        = !lt0_d && (index_h_d >= {1'b0, nh_d});
      step_valid_d = run_d;
      addr_x_d     = run_d ? k_d : '0;
      addr_y_d     = run_d ? n_d : '0;
      addr_h_d     = (run_d && !lt0_d && !oor_d) ? index_h_d[ADDR_WIDTH-1:0] : '0;
      acc_clear_d  = run_d && (k_d == '0);
      y_write_d    = run_d && ({1'b0, k_d} == (nx_d - 1'b1));
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
      if (!run_d) begin
         index_h_d = '0;
         lt0_d     = 1'b0;
         oor_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         nx_q         <= '0;
         nh_q         <= '0;
         step_valid_q <= 1'b0;
         addr_x_q     <= '0;
         addr_h_q     <= '0;
         addr_y_q     <= '0;
         index_h_q    <= '0;
         lt0_q        <= 1'b0;
         oor_q        <= 1'b0;
         acc_clear_q  <= 1'b0;
         y_write_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         nx_q         <= nx_d;
         nh_q         <= nh_d;
         step_valid_q <= step_valid_d;
         addr_x_q     <= addr_x_d;
         addr_h_q     <= addr_h_d;
         addr_y_q     <= addr_y_d;
         index_h_q    <= index_h_d;
         lt0_q        <= lt0_d;
         oor_q        <= oor_d;
         acc_clear_q  <= acc_clear_d;
         y_write_q    <= y_write_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign step_valid_o             = step_valid_q;
   assign addr_x_o                 = addr_x_q;
   assign addr_h_o                 = addr_h_q;
   assign addr_y_o                 = addr_y_q;
   assign index_h_o                = index_h_q;
   assign index_h_less_than_zero_o = lt0_q;
   assign index_h_out_of_range_o   = oor_q;
   assign acc_clear_o              = acc_clear_q;
   assign y_write_o                = y_write_q;
   assign busy_o                   = busy_q;
   assign done_o                   = done_q;

endmodule

`default_nettype wire

// File: doc/convolution_coprocessor_index_sequencer.md
Name: convolution_coprocessor_index_sequencer

Overview:
Control/address generator for the convolution coprocessor computing y[n] = sum over k of x[k]*h[n-k]. It walks n over 0..Nx+Nh-2 and k over 0..Nx-1, one (n,k) step per accepted cycle. For each step it emits X/H/Y addresses, the signed index n-k and its range flags, plus accumulator control. It sits directly upstream of the index-inversion/validity stage, which consumes index_h_less_than_zero_o, and of the MAC datapath.

Parameters:
ADDR_WIDTH, 5, address width of the X and H memories; maximum sequence length is 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_i  input  1  starts a convolution; sampled only in IDLE.
size_x_i  input  ADDR_WIDTH+1  Nx, latched on an accepted start.
size_h_i  input  ADDR_WIDTH+1  Nh, latched on an accepted start.
ready_i  input  1  downstream accepts the current step.
step_valid_o  output  1  current step outputs are valid.
addr_x_o  output  ADDR_WIDTH  k.
addr_h_o  output  ADDR_WIDTH  n-k when in range, else 0.
addr_y_o  output  ADDR_WIDTH+1  n.
index_h_o  output  ADDR_WIDTH+2  signed n-k.
index_h_less_than_zero_o  output  1  n-k < 0.
index_h_out_of_range_o  output  1  n-k >= Nh.
acc_clear_o  output  1  first step of an output n (k==0).
y_write_o  output  1  last step of an output n (k==Nx-1).
busy_o  output  1  high in RUN and DONE.
done_o  output  1  one-cycle pulse at completion.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; n=0, k=0; every output 0. Counters also clear.
- FSM IDLE:
  - On start_i=1, latch Nx and Nh. Sizes above 2^ADDR_WIDTH saturate to 2^ADDR_WIDTH.
  - If Nx==0 or Nh==0, go to DONE; no steps are emitted.
  - Otherwise go to RUN with n=0, k=0.
- FSM RUN:
  - All outputs are registered and decoded from the current (n,k). step_valid_o=1 throughout RUN.
  - A step is accepted when step_valid_o && ready_i.
  - On acceptance: if k<Nx-1, then k++; else k=0 and n++.
  - On acceptance of the last step (n==Nx+Nh-2, k==Nx-1), go to DONE; step_valid_o drops the next cycle.
  - When ready_i=0, every output holds its value (stall).
- FSM DONE: done_o=1 for exactly one cycle, busy_o=1; then go to IDLE.
- Latency: start accepted in cycle t gives the first step_valid_o in cycle t+1. With ready_i held at 1, there are Nx*(Nx+Nh-1) consecutive steps, and done_o is high in the cycle after the last step.
- Arithmetic:
  - index_h_o = zero-extended n minus zero-extended k, in ADDR_WIDTH+2-bit two's complement. It never overflows.
  - less_than_zero = sign bit.
  - out_of_range = (!sign && index_h >= Nh). The two flags are mutually exclusive.
  - addr_h_o is forced to 0 when either flag is set.
- acc_clear_o and y_write_o are both 1 on the same step when Nx==1.
- start_i in RUN or DONE is ignored; the latched sizes do not change mid-run.
- Reset mid-run: the run is abandoned immediately, with no done_o pulse.
- The sizes are sampled only in the IDLE start cycle.

Decomposition:
- Shared package convolution_coprocessor_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  - function conv_out_len(nx,nh), returning nx+nh-1.
- One natural sub-module: convolution_coprocessor_nested_counter. It holds the (n,k) pair with an advance input, inner limit Nx and outer limit Ny, and outputs inner_last and outer_last flags.
- The FSM, index subtraction and flag decode stay in the top module.

Test Plan:
- Nx=3, Nh=2, ready_i=1, start at cycle 0:
  - 12 steps in cycles 1..12, done_o in cycle 13.
  - index_h sequence: 0,-1,-2, 1,0,-1, 2,1,0, 3,2,1.
  - lt0 set on steps 2,3,6. out_of_range set on steps 7,10,11.
  - acc_clear on steps 1,4,7,10. y_write on steps 3,6,9,12.
- Same run with ready_i=0 in cycles 3..5: outputs frozen at step 3 (n=0, k=2, index_h=-2); done_o moves to cycle 16.
- Nx=0, Nh=4, start: busy_o=1 and done_o=1 in cycle 1, step_valid_o never asserts, back to IDLE in cycle 2.
- Nx=1, Nh=1: exactly one step with acc_clear_o=y_write_o=1 and index_h=0; done_o in the next cycle.
- start_i pulsed again mid-run with different sizes: step count stays Nx*(Nx+Nh-1) of the original sizes.
- rst asserted asynchronously mid-run (between clock edges): all outputs 0 immediately; after release, a new start runs normally from n=0, k=0.
